mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Parametrised successor to the single-beat valid/ready memory: on-chip RAM with burst read/write and per-byte write strobes.
- Separate command, write-data, read-data and write-response handshakes; read data is backpressurable.
- Out-of-range beats are flagged with an error instead of aliasing.
- Sits behind the testbench/driver interface as the storage target for burst traffic.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 64, number of words; must be ≤ 2**ADDR_WIDTH
ADDR_WIDTH, 6, word-address width
LEN_WIDTH, 4, burst length field width; beats per burst = cmd_len+1

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_wr_rd  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start word address
cmd_len  in  LEN_WIDTH  beats-1
wdata  in  WIDTH  write beat data
wstrb  in  WIDTH/8  byte enables, bit i -> wdata[8i+7:8i]
wvalid  in  1  write beat present
wready  out  1  write beat accepted when wvalid&&wready
rdata  out  WIDTH  read beat data
rvalid  out  1  read beat present
rready  in  1  read beat consumed when rvalid&&rready
rlast  out  1  current read beat is last of burst
rerr  out  1  current read beat address ≥ DEPTH
bvalid  out  1  write response present
bready  in  1  response consumed when bvalid&&bready
berr  out  1  any beat of the write burst was out of range

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: cmd_ready=0, wready=0, rvalid=0, rlast=0, rerr=0, rdata=0, bvalid=0, berr=0.
  - All DEPTH words cleared to 0; FSM returns to IDLE; beat counter and address register cleared.
  - Reset mid-burst aborts the burst; partially written words are then cleared by the reset itself.
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE:
  - cmd_ready=1 only when state==IDLE && !rvalid && !bvalid.
  - On accept: latch addr=cmd_addr, remaining=cmd_len, err_acc=0; go to WRITE if cmd_wr_rd=1, else READ.
- WRITE:
  - wready=1 throughout.
  - Each accepted beat, if addr<DEPTH: for each byte i with wstrb[i]=1, mem[addr] byte i = wdata byte i; unstrobed bytes unchanged.
  - If addr≥DEPTH: no write, set err_acc=1.
  - Then addr=addr+1 modulo 2**ADDR_WIDTH, no clamp. If remaining==0 go to WRESP, else remaining-1.
  - wvalid=0 stalls with no state change.
- WRESP:
  - bvalid=1, berr=err_acc.
  - On bvalid&&bready: bvalid=0, berr=0, go to IDLE.
- READ:
  - A beat is loaded on a posedge when !rvalid || rready.
  - Load: rdata=mem[addr] if addr<DEPTH, else 0; rerr=(addr≥DEPTH); rlast=(remaining==0); rvalid=1; addr increments.
  - Latency: command accepted at edge k gives first rvalid after edge k+1. With rready held high, beats are back-to-back, one per cycle.
  - After loading the last beat, go to IDLE. The output register holds until consumed; cmd_ready stays 0 until then.
  - rvalid&&rready with no new beat loaded clears rvalid, rlast and rerr; rdata holds.
  - rdata, rlast and rerr are stable while rvalid&&!rready.
- Write and read bursts never overlap (single outstanding command).
- Writes and reads happen in different states, so there is no read-during-write hazard.
- Inputs on inactive channels are ignored: wvalid outside WRITE; rready/bready when their valid is 0.

Test Plan:
- Reset: rst=1 for 2 cycles, then read addr 5 len 0 -> rdata=0, rlast=1, rerr=0; cmd_ready=1 after the beat is consumed.
- Write/read burst: write addr 10 len 3 with data 0x11,0x22,0x33,0x44, wstrb=4'hF; bready=1 -> bvalid one cycle, berr=0. Then read addr 10 len 3, rready=1 -> 4 consecutive beats 0x11..0x44, rlast only on the 4th.
- Byte strobes: write addr 2 data 0xAABBCCDD wstrb=4'hF, then data 0x11223344 wstrb=4'b0101 -> read addr 2 returns 0xAA22CC44.
- Backpressure: read addr 10 len 3 with rready toggling 1,0,0,1,1,0,1 -> every beat held stable while stalled; no beat lost or duplicated; order 0x11,0x22,0x33,0x44.
- Out of range and wrap (DEPTH=48, ADDR_WIDTH=6):
  - Write addr 46 len 3 -> words 46,47 written; beats at 48,49 dropped; berr=1.
  - Read addr 63 len 1 -> beat 1 rerr=1 rdata=0; beat 2 from addr 0, rerr=0.
- Reset mid-burst: assert rst after beat 2 of a write len 7 -> all outputs 0, cmd_ready=1 the cycle after rst drops, words 0..DEPTH-1 read back 0.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst-capable on-chip RAM with per-byte write strobes and separate
// command, write-data, read-data and write-response handshakes.
module mem_burst_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH/8-1:0]    wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [WIDTH-1:0]      rdata,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  rlast,
   output logic                  rerr,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  berr
);

   localparam int unsigned STRB_W = WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic                    err_q, err_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    wready_q, wready_d;
   logic [WIDTH-1:0]        rdata_q, rdata_d;
   logic                    rvalid_q, rvalid_d;
   logic                    rlast_q, rlast_d;
   logic                    rerr_q, rerr_d;
   logic                    bvalid_q, bvalid_d;
   logic                    berr_q, berr_d;

   logic [WIDTH-1:0]        mem_q [DEPTH];

   logic                    in_range;
   logic                    cmd_acc;
   logic                    wr_beat;
   logic                    rd_load;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign cmd_acc  = cmd_valid && cmd_ready_q;
   assign wr_beat  = (state_q == S_WRITE) && wvalid && wready_q;
   assign rd_load  = (state_q == S_READ) && (!rvalid_q || rready);

   // Next-state and next-output computation
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      rerr_d   = rerr_q;
      bvalid_d = bvalid_q;
      berr_d   = berr_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_acc) begin
               addr_d  = cmd_addr;
               rem_d   = cmd_len;
               err_d   = 1'b0;
               state_d = cmd_wr_rd ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (wr_beat) begin
               if (!in_range) err_d = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (rem_q == '0) begin
                  state_d  = S_WRESP;
                  bvalid_d = 1'b1;
                  berr_d   = err_q || !in_range;
               end else begin
                  rem_d = rem_q - LEN_WIDTH'(1);
               end
            end
         end
         S_WRESP: begin
            if (bvalid_q && bready) begin
               bvalid_d = 1'b0;
               berr_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_READ: begin
            if (rd_load) begin
               rdata_d  = in_range ? mem_q[addr_q] : '0;
               rerr_d   = !in_range;
               rlast_d  = (rem_q == '0);
               rvalid_d = 1'b1;
               addr_d   = addr_q + ADDR_WIDTH'(1);
               if (rem_q == '0) state_d = S_IDLE;
               else             rem_d   = rem_q - LEN_WIDTH'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Consumed beat with nothing behind it empties the output register
      if (!rd_load && rvalid_q && rready) begin
         rvalid_d = 1'b0;
         rlast_d  = 1'b0;
         rerr_d   = 1'b0;
      end

      wready_d    = (state_d == S_WRITE);
      cmd_ready_d = (state_d == S_IDLE) && !rvalid_d && !bvalid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
         wready_q    <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
         rerr_q      <= 1'b0;
         bvalid_q    <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
         wready_q    <= wready_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
         rerr_q      <= rerr_d;
         bvalid_q    <= bvalid_d;
         berr_q      <= berr_d;
      end
   end

   // Storage array: cleared by reset, byte-strobed writes for in-range beats only
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (wr_beat && in_range) begin
         for (int unsigned i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) mem_q[addr_q][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign wready    = wready_q;
   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign rlast     = rlast_q;
   assign rerr      = rerr_q;
   assign bvalid    = bvalid_q;
   assign berr      = berr_q;

endmodule
